// File: rtl/axi_read_arbiter_rr.sv
// N-master AXI read arbiter: merges per-master AR channels onto one downstream AR channel
// (round-robin or fixed priority, per-master outstanding-burst limits) and routes R beats
// back to the requesting master by RID.
module axi_read_arbiter_rr #(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ARB_MODE        = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  // Upstream read masters
  input  logic [NUM_MASTERS-1:0]            m_arvalid_i,
  output logic [NUM_MASTERS-1:0]            m_arready_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr_i,
  input  logic [NUM_MASTERS*4-1:0]          m_arlen_i,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  input  logic [NUM_MASTERS-1:0]            m_rready_i,
  output logic                              m_rlast_o,
  output logic [DATA_WIDTH-1:0]             m_rdata_o,
  // Downstream AXI read channels
  output logic                              arvalid_o,
  input  logic                              arready_i,
  output logic [3:0]                        arid_o,
  output logic [3:0]                        arlen_o,
  output logic [ADDR_WIDTH-1:0]             araddr_o,
  input  logic                              rvalid_i,
  output logic                              rready_o,
  input  logic                              rlast_i,
  input  logic [3:0]                        rid_i,
  input  logic [DATA_WIDTH-1:0]             rdata_i,
  output logic                              err_stray_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             rr_ptr_q, rr_ptr_d;
  logic [3:0]             arid_q, arid_d;
  logic [3:0]             arlen_q, arlen_d;
  logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [CntW-1:0]        cnt_q [NUM_MASTERS];
  logic [CntW-1:0]        cnt_d [NUM_MASTERS];
  logic                   err_stray_q, err_stray_d;

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] eligible_rot;
  logic                   grant_valid;
  logic [3:0]             grant_idx;
  logic                   rid_stray;

  // A master may be granted only while it has room for another in-flight burst
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      eligible[i] = m_arvalid_i[i] && (cnt_q[i] < CntW'(MAX_OUTSTANDING));
    end
  end

  // Grant selection: scan from rr_ptr with wrap (RR) or from index 0 (fixed priority)
  always_comb begin
    grant_valid  = 1'b0;
    grant_idx    = '0;
    eligible_rot = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      int unsigned idx;
      idx = k;
      if (ARB_MODE == 0) begin
        idx = k + 32'(rr_ptr_q);
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      end
      eligible_rot = eligible >> idx;
      if (!grant_valid && eligible_rot[0]) begin
        grant_valid = 1'b1;
        grant_idx   = 4'(idx);
      end
    end
  end

  // Accept pulse is combinational in IDLE only, so ARREADY never reaches m_arready
  always_comb begin
    m_arready_o = '0;
    if (state_q == StIdle && grant_valid && !rst_i) begin
      m_arready_o = NUM_MASTERS'(1) << grant_idx;
    end
  end

  // AR FSM next state: latch the granted request in IDLE, hold it stable in ISSUE
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    arid_d   = arid_q;
    arlen_d  = arlen_q;
    araddr_d = araddr_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          arid_d  = grant_idx;
          state_d = StIssue;
          for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_idx == 4'(i)) begin
              arlen_d  = m_arlen_i[i*4 +: 4];
              araddr_d = m_araddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
          end
        end
      end
      StIssue: begin
        if (arready_i) begin
          state_d = StIdle;
          if (ARB_MODE == 0) begin
            rr_ptr_d = (arid_q == 4'(NUM_MASTERS - 1)) ? 4'd0 : arid_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign arvalid_o = (state_q == StIssue);
  assign arid_o    = arid_q;
  assign arlen_o   = arlen_q;
  assign araddr_o  = araddr_q;

  // R routing by RID; an out-of-range RID is sunk and flagged
  always_comb begin
    m_rvalid_o = '0;
    rready_o   = 1'b1;
    rid_stray  = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (rid_i == 4'(i)) begin
        m_rvalid_o[i] = rvalid_i;
        rready_o      = m_rready_i[i];
        rid_stray     = 1'b0;
      end
    end
    err_stray_d = err_stray_q | (rvalid_i & rid_stray);
  end

  assign m_rlast_o   = rlast_i;
  assign m_rdata_o   = rdata_i;
  assign err_stray_o = err_stray_q;

  // Outstanding-burst counters: +1 on AR accept, -1 on the last R beat of a burst
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      logic inc, dec;
      inc      = m_arvalid_i[i] & m_arready_o[i];
      dec      = rvalid_i & rready_o & rlast_i & (rid_i == 4'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - CntW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      arid_q      <= '0;
      arlen_q     <= '0;
      araddr_q    <= '0;
      err_stray_q <= 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      arid_q      <= arid_d;
      arlen_q     <= arlen_d;
      araddr_q    <= araddr_d;
      err_stray_q <= err_stray_d;
      for (int i = 0; i < NUM_MASTERS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter_rr.sv
// Directed bench for axi_read_arbiter_rr: one round-robin instance and one fixed-priority one.
module tb_axi_read_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk, rst;

  // Round-robin instance
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*AW-1:0] m_araddr;
  logic [N*4-1:0]  m_arlen;
  logic            m_rlast;
  logic [DW-1:0]   m_rdata;
  logic            arvalid, arready, rvalid, rready, rlast, err_stray;
  logic [3:0]      arid, arlen, rid;
  logic [AW-1:0]   araddr;
  logic [DW-1:0]   rdata;

  // Fixed-priority instance, R channel left idle
  logic [N-1:0]    f_m_arvalid, f_m_arready, f_m_rvalid, f_m_rready;
  logic [N*AW-1:0] f_m_araddr;
  logic [N*4-1:0]  f_m_arlen;
  logic            f_m_rlast;
  logic [DW-1:0]   f_m_rdata;
  logic            f_arvalid, f_arready, f_rvalid, f_rready, f_rlast, f_err_stray;
  logic [3:0]      f_arid, f_arlen, f_rid;
  logic [AW-1:0]   f_araddr;
  logic [DW-1:0]   f_rdata;

  int n_checks = 0;
  int n_errors = 0;

  axi_read_arbiter_rr #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2), .ARB_MODE(0)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .m_arvalid_i(m_arvalid), .m_arready_o(m_arready), .m_araddr_i(m_araddr),
    .m_arlen_i(m_arlen), .m_rvalid_o(m_rvalid), .m_rready_i(m_rready),
    .m_rlast_o(m_rlast), .m_rdata_o(m_rdata),
    .arvalid_o(arvalid), .arready_i(arready), .arid_o(arid), .arlen_o(arlen),
    .araddr_o(araddr), .rvalid_i(rvalid), .rready_o(rready), .rlast_i(rlast),
    .rid_i(rid), .rdata_i(rdata), .err_stray_o(err_stray)
  );

  axi_read_arbiter_rr #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2), .ARB_MODE(1)
  ) u_dut_fp (
    .clk_i(clk), .rst_i(rst),
    .m_arvalid_i(f_m_arvalid), .m_arready_o(f_m_arready), .m_araddr_i(f_m_araddr),
    .m_arlen_i(f_m_arlen), .m_rvalid_o(f_m_rvalid), .m_rready_i(f_m_rready),
    .m_rlast_o(f_m_rlast), .m_rdata_o(f_m_rdata),
    .arvalid_o(f_arvalid), .arready_i(f_arready), .arid_o(f_arid), .arlen_o(f_arlen),
    .araddr_o(f_araddr), .rvalid_i(f_rvalid), .rready_o(f_rready), .rlast_i(f_rlast),
    .rid_i(f_rid), .rdata_i(f_rdata), .err_stray_o(f_err_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_rr[6] = '{0, 1, 3, 0, 1, 3};
  int exp_fp[4] = '{0, 0, 2, 2};

  initial begin
    rst         = 1'b1;
    m_arvalid   = '0; m_rready = '0; arready = 1'b0;
    rvalid      = 1'b0; rlast = 1'b0; rid = '0; rdata = '0;
    f_m_arvalid = '0; f_m_rready = '0; f_arready = 1'b0;
    f_rvalid    = 1'b0; f_rlast = 1'b0; f_rid = '0; f_rdata = '0;
    for (int i = 0; i < N; i++) begin
      m_araddr[i*AW +: AW]   = 32'h1000_0000 + 32'(i * 16);
      m_arlen[i*4 +: 4]      = 4'(i);
      f_m_araddr[i*AW +: AW] = 32'h2000_0000 + 32'(i * 16);
      f_m_arlen[i*4 +: 4]    = 4'(i);
    end

    // Reset state
    #2;
    check("rst_arvalid",   64'(arvalid),   64'(0));
    check("rst_arid",      64'(arid),      64'(0));
    check("rst_arlen",     64'(arlen),     64'(0));
    check("rst_araddr",    64'(araddr),    64'(0));
    check("rst_m_arready", 64'(m_arready), 64'(0));
    check("rst_m_rvalid",  64'(m_rvalid),  64'(0));
    check("rst_err",       64'(err_stray), 64'(0));
    check("rst_f_arvalid", 64'(f_arvalid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset asserted while in ISSUE drops ARVALID immediately
    m_arvalid = 4'b0100;
    #1;
    check("grant_m2_ready", 64'(m_arready), 64'(4'b0100));
    tick();
    check("issue_arvalid", 64'(arvalid), 64'(1));
    check("issue_arid",    64'(arid),    64'(2));
    check("issue_araddr",  64'(araddr),  64'(32'h1000_0020));
    rst = 1'b1;
    #1;
    check("midrst_arvalid", 64'(arvalid),   64'(0));
    check("midrst_arid",    64'(arid),      64'(0));
    check("midrst_ready",   64'(m_arready), 64'(0));
    m_arvalid = '0;
    rst       = 1'b0;
    tick();

    // Round-robin among masters 0,1,3 with prompt RLAST returns
    m_rready  = 4'hF;
    arready   = 1'b1;
    m_arvalid = 4'b1011;
    for (int g = 0; g < 6; g++) begin
      int w;
      logic [3:0] oh;
      w = 0;
      while (!arvalid && w < 10) begin
        tick();
        w++;
      end
      check("rr_arvalid", 64'(arvalid), 64'(1));
      check("rr_arid",    64'(arid),    64'(exp_rr[g]));
      check("rr_araddr",  64'(araddr),  64'(32'h1000_0000 + 32'(exp_rr[g] * 16)));
      check("rr_arlen",   64'(arlen),   64'(exp_rr[g]));
      rvalid = 1'b1;
      rid    = 4'(exp_rr[g]);
      rlast  = 1'b1;
      oh     = 4'b0001 << exp_rr[g];
      #1;
      check("rr_m_rvalid", 64'(m_rvalid), 64'(oh));
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
    end
    m_arvalid = '0;
    arready   = 1'b0;
    tick();

    // ARREADY held low: request held stable, no further accepts
    m_arvalid         = 4'b0010;
    m_arlen[7:4]      = 4'd5;
    m_araddr[63:32]   = 32'h1000_0040;
    tick();
    m_araddr[63:32]   = 32'hDEAD_BEEF;
    m_arlen[7:4]      = 4'd9;
    for (int c = 0; c < 5; c++) begin
      check("hold_ar", {19'd0, arvalid, arid, arlen, araddr, m_arready},
            {19'd0, 1'b1, 4'd1, 4'd5, 32'h1000_0040, 4'b0000});
      tick();
    end
    arready   = 1'b1;
    m_arvalid = '0;
    tick();

    // Second burst for master 1 fills its limit; a 4-beat burst frees one slot on RLAST
    m_arvalid    = 4'b0010;
    m_arlen[7:4] = 4'd3;
    #1;
    check("m1_second_ready", 64'(m_arready), 64'(4'b0010));
    tick();
    check("m1_issue_arlen", 64'(arlen), 64'(3));
    check("m1_issue_arid",  64'(arid),  64'(1));
    tick();
    check("m1_full_ready", 64'(m_arready), 64'(0));
    begin
      int b;
      b = 0;
      for (int c = 0; c < 8; c++) begin
        logic rdy;
        rdy      = (c % 2 == 1);
        rvalid   = 1'b1;
        rid      = 4'd1;
        rdata    = 32'hC0DE_0000 + 32'(b);
        rlast    = (b == 3);
        m_rready = {2'b00, rdy, 1'b1};
        #1;
        check("burst_m_rvalid", 64'(m_rvalid),  64'(4'b0010));
        check("burst_rready",   64'(rready),    64'(rdy));
        check("burst_rdata",    64'(m_rdata),   64'(32'hC0DE_0000 + 32'(b)));
        check("burst_rlast",    64'(m_rlast),   64'(b == 3));
        check("burst_no_slot",  64'(m_arready), 64'(0));
        tick();
        if (rdy) b++;
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      check("burst_beats", 64'(b), 64'(4));
    end
    #1;
    check("after_rlast_ready", 64'(m_arready), 64'(4'b0010));
    m_arvalid = '0;
    tick();

    // Stray RID is sunk and sets the sticky error
    rvalid   = 1'b1;
    rid      = 4'd7;
    rlast    = 1'b1;
    m_rready = '0;
    #1;
    check("stray_rready",  64'(rready),    64'(1));
    check("stray_m_rvalid", 64'(m_rvalid), 64'(0));
    check("stray_err_pre", 64'(err_stray), 64'(0));
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rid    = 4'd0;
    check("stray_err_set", 64'(err_stray), 64'(1));
    tick();
    tick();
    check("stray_err_sticky", 64'(err_stray), 64'(1));
    rst = 1'b1;
    #1;
    check("stray_err_rst", 64'(err_stray), 64'(0));
    rst = 1'b0;
    tick();

    // Fixed priority, masters 0 and 2, no R traffic: 0,0,2,2 then stall
    f_arready   = 1'b1;
    f_m_arvalid = 4'b0101;
    begin
      int ngr;
      ngr = 0;
      for (int c = 0; c < 20; c++) begin
        if (f_arvalid) begin
          if (ngr < 4) check("fp_arid", 64'(f_arid), 64'(exp_fp[ngr]));
          ngr++;
        end
        tick();
      end
      check("fp_grant_count", 64'(ngr), 64'(4));
      check("fp_stalled_ready", 64'(f_m_arready), 64'(0));
    end
    f_m_arvalid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
